// File: rtl/instr_prefetch_reg_pkg.sv
// Shared types and helpers for the instruction prefetch register and its queue.
package instr_prefetch_reg_pkg;

   // Assembler state: waiting for an opcode byte, or for the operand byte of a long instruction
   typedef enum logic {
      ST_FIRST  = 1'b0,
      ST_SECOND = 1'b1
   } ipr_state_e;

   // Default configuration of the original 8-bit machine
   localparam int unsigned IPR_BUS_W_DEF   = 8;
   localparam int unsigned IPR_OPC_W_DEF   = 4;
   localparam int unsigned IPR_DEPTH_DEF   = 2;
   localparam int unsigned IPR_LONG_EN_DEF = 1;

   // Pointer width for a queue of 'depth' slots (at least one bit)
   function automatic int unsigned ipr_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width able to hold 0..depth
   function automatic int unsigned ipr_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/instr_prefetch_reg_fifo.sv
// Generic show-ahead FIFO: head entry is readable without a pop; flush empties it in one edge.
module ipr_fifo
   import instr_prefetch_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = ipr_ptr_w(DEPTH);
   localparam int unsigned CNT_W = ipr_cnt_w(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign rdata_o = mem_q[rd_ptr_q];

   // Next pointer/count state; flush overrides any push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: stale slots are never observed while the queue is empty
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/instr_prefetch_reg.sv
// Instruction prefetch register: assembles short/long instructions from bus bytes into a
// show-ahead queue and presents the head opcode/operand to the control unit.
module instr_prefetch_reg
   import instr_prefetch_reg_pkg::*;
#(
   parameter int unsigned BUS_W   = IPR_BUS_W_DEF,
   parameter int unsigned OPC_W   = IPR_OPC_W_DEF,
   parameter int unsigned DEPTH   = IPR_DEPTH_DEF,
   parameter int unsigned LONG_EN = IPR_LONG_EN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ii,
   input  logic [BUS_W-1:0] bus,
   input  logic             ir_next,
   input  logic             flush,
   output logic             full,
   output logic             ir_valid,
   output logic [OPC_W-1:0] opcode,
   output logic [BUS_W-1:0] operand,
   output logic             is_long,
   output logic             ovf_err
);

   typedef struct packed {
      logic             is_long;
      logic [BUS_W-1:0] byte0;
      logic [BUS_W-1:0] byte1;
   } entry_t;

   localparam int unsigned ENT_W = $bits(entry_t);
   localparam int unsigned IMM_W = BUS_W - OPC_W;

   ipr_state_e       state_q;
   logic [BUS_W-1:0] hold_q;
   logic             ovf_q;

   logic             accept_w;
   logic             long_first_w;
   logic             push_w;
   entry_t           push_entry_w;
   entry_t           head_w;
   logic [ENT_W-1:0] head_raw_w;
   logic             full_w;
   logic             empty_w;

   assign accept_w     = ii & ~full_w & ~flush;
   assign long_first_w = (LONG_EN != 0) & bus[BUS_W-1];
   assign head_w       = entry_t'(head_raw_w);

   // Decide whether the accepted byte completes an instruction and build the queue entry
   always_comb begin
      push_w       = 1'b0;
      push_entry_w = '0;
      if (accept_w) begin
         case (state_q)
            ST_FIRST: begin
               if (!long_first_w) begin
                  push_w             = 1'b1;
                  push_entry_w.byte0 = bus;
               end
            end
            ST_SECOND: begin
               push_w               = 1'b1;
               push_entry_w.is_long = 1'b1;
               push_entry_w.byte0   = hold_q;
               push_entry_w.byte1   = bus;
            end
            default: push_w = 1'b0;
         endcase
      end
   end

   // Assembler FSM, opcode hold register and sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FIRST;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
      end else if (flush) begin
         state_q <= ST_FIRST;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (ii && full_w) ovf_q <= 1'b1;
         if (accept_w) begin
            case (state_q)
               ST_FIRST: begin
                  if (long_first_w) begin
                     hold_q  <= bus;
                     state_q <= ST_SECOND;
                  end
               end
               ST_SECOND: begin
                  hold_q  <= '0;
                  state_q <= ST_FIRST;
               end
               default: state_q <= ST_FIRST;
            endcase
         end
      end
   end

   ipr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push_w),
      .pop_i   (ir_next),
      .flush_i (flush),
      .wdata_i (push_entry_w),
      .rdata_o (head_raw_w),
      .full_o  (full_w),
      .empty_o (empty_w)
   );

   // Format the head entry for the control unit; everything reads zero when the queue is empty
   always_comb begin
      opcode   = '0;
      operand  = '0;
      is_long  = 1'b0;
      ir_valid = ~empty_w;
      if (!empty_w) begin
         opcode  = head_w.byte0[BUS_W-1 -: OPC_W];
         is_long = head_w.is_long;
         if (head_w.is_long) operand = head_w.byte1;
         else                operand[IMM_W-1:0] = head_w.byte0[IMM_W-1:0];
      end
   end

   assign full    = full_w;
   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_instr_prefetch_reg.sv
// Self-checking bench for instr_prefetch_reg (BUS_W=8, OPC_W=4, DEPTH=2, LONG_EN=1).
module tb_instr_prefetch_reg;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ii = 1'b0;
   logic [7:0] bus = 8'h00;
   logic       ir_next = 1'b0;
   logic       flush = 1'b0;
   logic       full, ir_valid, is_long, ovf_err;
   logic [3:0] opcode;
   logic [7:0] operand;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instr_prefetch_reg #(
      .BUS_W   (8),
      .OPC_W   (4),
      .DEPTH   (DEPTH),
      .LONG_EN (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ii       (ii),
      .bus      (bus),
      .ir_next  (ir_next),
      .flush    (flush),
      .full     (full),
      .ir_valid (ir_valid),
      .opcode   (opcode),
      .operand  (operand),
      .is_long  (is_long),
      .ovf_err  (ovf_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a queue of decoded instructions ----------------
   typedef struct {
      logic       lng;
      logic [3:0] opc;
      logic [7:0] opd;
   } m_ent_t;

   m_ent_t     mq[$];
   logic       m_pend = 1'b0;
   logic [7:0] m_hold = 8'h00;
   logic       m_ovf  = 1'b0;
   int         m_sz;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_pend = 1'b0;
         m_hold = 8'h00;
         m_ovf  = 1'b0;
      end else if (flush) begin
         mq.delete();
         m_pend = 1'b0;
         m_hold = 8'h00;
         m_ovf  = 1'b0;
      end else begin
         m_sz = mq.size();
         if (ii && m_sz == DEPTH) m_ovf = 1'b1;
         if (ir_next && m_sz > 0) void'(mq.pop_front());
         if (ii && m_sz < DEPTH) begin
            if (m_pend) begin
               mq.push_back('{1'b1, m_hold[7:4], bus});
               m_pend = 1'b0;
            end else if (bus[7]) begin
               m_pend = 1'b1;
               m_hold = bus;
            end else begin
               mq.push_back('{1'b0, bus[7:4], {4'h0, bus[3:0]}});
            end
         end
      end
   end

   // Every-cycle comparison against the model, half a cycle after the active edge
   always @(negedge clk) begin
      if (mq.size() > 0) begin
         chk("ir_valid", ir_valid, 1);
         chk("opcode",   opcode,   mq[0].opc);
         chk("operand",  operand,  mq[0].opd);
         chk("is_long",  is_long,  mq[0].lng);
      end else begin
         chk("ir_valid", ir_valid, 0);
         chk("opcode",   opcode,   0);
         chk("operand",  operand,  0);
         chk("is_long",  is_long,  0);
      end
      chk("full",    full,    (mq.size() == DEPTH) ? 1 : 0);
      chk("ovf_err", ovf_err, m_ovf);
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic i, input logic [7:0] b, input logic nx, input logic fl);
      ii = i; bus = b; ir_next = nx; flush = fl;
      @(posedge clk);
      #1;
      ii = 1'b0; bus = 8'h00; ir_next = 1'b0; flush = 1'b0;
   endtask

   typedef struct {
      logic       i;
      logic [7:0] b;
      logic       nx;
      logic       fl;
   } vec_t;

   vec_t tbl[16] = '{
      '{1'b1, 8'h9F, 1'b0, 1'b0}, '{1'b1, 8'h55, 1'b0, 1'b0},
      '{1'b1, 8'hA1, 1'b0, 1'b0}, '{1'b1, 8'hB2, 1'b0, 1'b0},
      '{1'b1, 8'h66, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b1, 8'h81, 1'b1, 1'b0}, '{1'b1, 8'h7E, 1'b0, 1'b0},
      '{1'b1, 8'h01, 1'b1, 1'b1}, '{1'b1, 8'h0F, 1'b0, 1'b0},
      '{1'b1, 8'h8C, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b1, 8'hF0, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b1, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0}
   };

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // reset state
      chk("rst_valid",   ir_valid, 0);
      chk("rst_full",    full,     0);
      chk("rst_ovf",     ovf_err,  0);
      chk("rst_opcode",  opcode,   0);
      chk("rst_operand", operand,  0);

      // short instruction
      step(1, 8'h3A, 0, 0);
      chk("short_valid",   ir_valid, 1);
      chk("short_opcode",  opcode,   4'h3);
      chk("short_operand", operand,  8'h0A);
      chk("short_islong",  is_long,  0);
      step(0, 8'h00, 1, 0);
      chk("short_popped",  ir_valid, 0);

      // long instruction
      step(1, 8'h9F, 0, 0);
      chk("long_half_valid", ir_valid, 0);
      step(1, 8'h55, 0, 0);
      chk("long_opcode",  opcode,  4'h9);
      chk("long_operand", operand, 8'h55);
      chk("long_islong",  is_long, 1);
      step(0, 8'h00, 1, 0);

      // full and overflow with a same-cycle pop
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      chk("full_set", full, 1);
      step(1, 8'h33, 1, 0);
      chk("ovf_set",      ovf_err, 1);
      chk("ovf_opcode",   opcode,  4'h2);
      chk("ovf_operand",  operand, 8'h02);
      chk("ovf_full_clr", full,    0);
      step(0, 8'h00, 1, 0);
      chk("ovf_33_dropped", ir_valid, 0);
      chk("ovf_sticky",     ovf_err,  1);

      // flush drops a half-assembled long instruction and the concurrent byte
      step(1, 8'hC0, 0, 0);
      chk("flush_half_valid", ir_valid, 0);
      step(1, 8'h44, 0, 1);
      chk("flush_valid", ir_valid, 0);
      chk("flush_ovf",   ovf_err,  0);
      step(1, 8'h44, 0, 0);
      chk("flush_opcode",  opcode,  4'h4);
      chk("flush_operand", operand, 8'h04);
      chk("flush_islong",  is_long, 0);

      // simultaneous push and pop, then pop on empty
      step(1, 8'h52, 1, 0);
      chk("conc_opcode",  opcode,   4'h5);
      chk("conc_operand", operand,  8'h02);
      chk("conc_full",    full,     0);
      step(0, 8'h00, 1, 0);
      chk("conc_empty",   ir_valid, 0);
      step(0, 8'h00, 1, 0);
      chk("pop_empty_valid", ir_valid, 0);
      chk("pop_empty_full",  full,     0);

      // asynchronous reset in the middle of a long instruction
      step(1, 8'h3A, 0, 0);
      step(1, 8'hA7, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid",   ir_valid, 0);
      chk("arst_opcode",  opcode,   0);
      chk("arst_operand", operand,  0);
      chk("arst_full",    full,     0);
      chk("arst_ovf",     ovf_err,  0);
      @(posedge clk);
      #1 rst = 1'b1;
      step(1, 8'h12, 0, 0);
      chk("arst_short_opcode",  opcode,  4'h1);
      chk("arst_short_operand", operand, 8'h02);
      chk("arst_short_islong",  is_long, 0);
      step(0, 8'h00, 1, 0);

      // mixed table, checked by the model every cycle
      for (int k = 0; k < 16; k++) step(tbl[k].i, tbl[k].b, tbl[k].nx, tbl[k].fl);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
